mem_access_unit: RTL

Load/store sequencer between the execute stage and the distributed data memory (async-read `spo`, sync-write `we`, word-addressed `a`, 32-bit `d`). It accepts one byte/half/word load or store per request and checks alignment. Sub-word stores are done as read-modify-write, because the memory has a single whole-word write enable. Load data is returned sign- or zero-extended through a valid/ready response handshake.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//   Request/response handshake between the execute stage and mem_access_unit.
//   master : the requester (execute stage or testbench)
//   slave  : mem_access_unit
//   Signals:
//     req_valid / req_ready         request handshake
//     req_op[2:0]                   LB, LBU, LH, LHU, LW, SB, SH, SW
//     req_addr[31:0]                byte address
//     req_wdata[31:0]               store data; sub-word stores use the low bits
//     resp_valid / resp_ready       response handshake
//     resp_rdata[31:0]              extended load data; 0 for stores and errors
//     resp_addr_err                 request was misaligned and had no effect
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_addr_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_addr_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_addr_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store sequencer in front of a distributed data memory with an
//   asynchronous read port (mem_spo) and a synchronous whole-word write port.
//   Byte and halfword stores are read-modify-write: the current word is read,
//   the addressed lane replaced, then the whole word written back.
//   Ports:
//     clk, resetn      clock, asynchronous active-low reset
//     bus (slave)      request/response handshake, see mem_access_unit_if
//     mem_a            word address (byte address bits [ADDR_W+1:2])
//     mem_d, mem_we    write data / write enable (high in WRITE only)
//     mem_spo          asynchronous read data for mem_a
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_d,
  output logic              mem_we,
  input  logic [31:0]       mem_spo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  logic [2:0]        r_state;
  logic [2:0]        r_op;
  logic [ADDR_W+1:0] r_addr;      // only the bits that reach the memory, so addresses wrap
  logic [15:0]       r_wdata;     // sub-word store data; SW data goes straight to r_merge
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              r_addr_err;

  logic        w_misaligned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic        w_unused_addr;

  // Upper address bits are deliberately dropped (memory aliasing).
  assign w_unused_addr = &{1'b0, bus.req_addr[31:ADDR_W+2]};

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.req_op)
      OP_LH, OP_LHU, OP_SH: w_misaligned = bus.req_addr[0];
      OP_LW, OP_SW:         w_misaligned = |bus.req_addr[1:0];
      default:              w_misaligned = 1'b0;
    endcase
  end

  // Little-endian lane extraction and extension for loads.
  always_comb begin
    w_byte = mem_spo[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = mem_spo[7:0];
      2'b01:   w_byte = mem_spo[15:8];
      2'b10:   w_byte = mem_spo[23:16];
      default: w_byte = mem_spo[31:24];
    endcase
    w_half = r_addr[1] ? mem_spo[31:16] : mem_spo[15:0];
    case (r_op)
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load = {24'd0, w_byte};
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load = {16'd0, w_half};
      default: w_load = mem_spo;
    endcase
  end

  // Read-modify-write: replace only the addressed lane of the current word.
  always_comb begin
    w_merged = mem_spo;
    if (r_op == OP_SB) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_op       <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 16'd0;
      r_merge    <= 32'd0;
      r_rdata    <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op       <= bus.req_op;
            r_addr     <= bus.req_addr[ADDR_W+1:0];
            r_wdata    <= bus.req_wdata[15:0];
            r_rdata    <= 32'd0;
            r_addr_err <= w_misaligned;
            if (w_misaligned) begin
              r_state <= S_RESP;
            end else begin
              case (bus.req_op)
                OP_SW: begin
                  r_merge <= bus.req_wdata;
                  r_state <= S_WRITE;
                end
                OP_SB, OP_SH: r_state <= S_MERGE;
                default:      r_state <= S_LOAD;
              endcase
            end
          end
        end
        S_LOAD: begin
          r_rdata <= w_load;
          r_state <= S_RESP;
        end
        S_MERGE: begin
          r_merge <= w_merged;
          r_state <= S_WRITE;
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP: begin
          if (bus.resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and write enable are decoded from state so that an async reset
  // removes them immediately.
  assign bus.req_ready     = (r_state == S_IDLE);
  assign bus.resp_valid    = (r_state == S_RESP);
  assign bus.resp_rdata    = r_rdata;
  assign bus.resp_addr_err = r_addr_err;
  assign mem_we            = (r_state == S_WRITE);
  assign mem_a             = r_addr[ADDR_W+1:2];
  assign mem_d             = r_merge;

endmodule
